dcache_nb: RTL and testbench

- Non-blocking, write-back, write-allocate L1 data cache with an integrated 4-entry miss status holding register (MSHR) and a word-addressed backing memory model.
- Sits between the CPU load/store stage and memory.
- Hits, and stores that miss, complete in the request cycle.
- Load misses retire later through an out-of-band completion that is reported to the CPU with a destination register.

---
 rtl/dcache_nb.sv | 209 ++++++++++++++++++++
 tb/tb_dcache_nb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nb.sv
`default_nettype none
// ============================================================================
// Module   : dcache_nb
// Brief    : Non-blocking write-back/write-allocate 2-way L1 data cache with
//            an in-order MSHR and a word-addressed backing memory model.
// Revision : 1.0
// ============================================================================
module dcache_nb #(
  parameter int MSHR_DEPTH  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int MEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_pulse,
  input  logic        lw,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data,
  input  logic [4:0]  regD_in,
  output logic        hit_ack,
  output logic        miss_send,
  output logic [4:0]  regD_out,
  output logic [31:0] load_data,
  output logic        load_done_stall,
  output logic        passive_stall
);
  localparam int c_SETS = 64;
  localparam int c_PW   = $clog2(MSHR_DEPTH);
  localparam int c_CW   = $clog2(MSHR_DEPTH + 1);
  localparam int c_LW   = $clog2(MEM_LATENCY + 1);
  localparam int c_MW   = $clog2(MEM_WORDS);

  logic [c_SETS-1:0] r_valid [2];
  logic [c_SETS-1:0] r_dirty [2];
  logic [c_SETS-1:0] r_pend  [2];
  logic [c_SETS-1:0] r_mru;
  logic [23:0]       r_tag   [2][c_SETS];
  logic [31:0]       r_data  [2][c_SETS];
  logic [31:0]       r_mem   [MEM_WORDS] = '{default: '0};

  logic [MSHR_DEPTH-1:0] r_occ;
  logic                  r_eload [MSHR_DEPTH];
  logic [29:0]           r_eaddr [MSHR_DEPTH];
  logic [31:0]           r_edata [MSHR_DEPTH];
  logic [4:0]            r_erd   [MSHR_DEPTH];
  logic                  r_eway  [MSHR_DEPTH];
  logic [c_PW-1:0]       r_head, r_tail;
  logic [c_CW-1:0]       r_count;
  logic [c_LW-1:0]       r_lat;

  logic [5:0]      w_set, w_hset;
  logic [23:0]     w_tag;
  logic            w_hit0, w_hit1, w_hit, w_hway, w_vway, w_vdirty, w_vpend;
  logic            w_match, w_done, w_ld_done, w_block, w_acc;
  logic            w_enq_ld, w_enq_ev;
  logic [c_CW-1:0] w_need, w_free;
  logic [c_PW-1:0] w_tail1, w_tail2, w_ev_slot;
  logic [31:0]     w_mem_rd;
  logic            w_unused;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(MSHR_DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  assign w_set    = addr_in[7:2];
  assign w_tag    = addr_in[31:8];
  assign w_hit0   = r_valid[0][w_set] && (r_tag[0][w_set] == w_tag);
  assign w_hit1   = r_valid[1][w_set] && (r_tag[1][w_set] == w_tag);
  assign w_hit    = w_hit0 || w_hit1;
  assign w_hway   = w_hit1;
  // Free (invalid, not in flight) ways are preferred over evicting the LRU way
  assign w_vway   = (!r_valid[0][w_set] && !r_pend[0][w_set]) ? 1'b0 :
                    (!r_valid[1][w_set] && !r_pend[1][w_set]) ? 1'b1 : ~r_mru[w_set];
  assign w_vdirty = r_valid[w_vway][w_set] && r_dirty[w_vway][w_set];
  assign w_vpend  = r_pend[w_vway][w_set];
  assign w_free   = c_CW'(MSHR_DEPTH) - r_count;
  assign w_unused = ^addr_in[1:0];

  always_comb begin
    w_need = '0;
    if (!w_hit) begin
      if (lw)       w_need = w_need + c_CW'(1);
      if (w_vdirty) w_need = w_need + c_CW'(1);
    end
  end

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < MSHR_DEPTH; i++)
      if (r_occ[i] && (r_eaddr[i] == addr_in[31:2])) w_match = 1'b1;
  end

  assign w_done    = (r_count != '0) && (r_lat == c_LW'(MEM_LATENCY - 1));
  assign w_ld_done = w_done && r_eload[r_head];
  assign w_block   = w_match || (w_need > w_free) || (!w_hit && w_vpend);
  assign w_acc     = send_pulse && !w_ld_done && !w_block;
  assign w_enq_ld  = w_acc && !w_hit && lw;
  assign w_enq_ev  = w_acc && !w_hit && w_vdirty;
  assign w_hset    = r_eaddr[r_head][5:0];
  assign w_mem_rd  = r_mem[r_eaddr[r_head][c_MW-1:0]];
  assign w_tail1   = f_inc(r_tail);
  assign w_tail2   = f_inc(w_tail1);
  assign w_ev_slot = w_enq_ld ? w_tail1 : r_tail;

  always_comb begin
    hit_ack         = 1'b0;
    miss_send       = 1'b0;
    regD_out        = '0;
    load_data       = '0;
    load_done_stall = 1'b0;
    passive_stall   = 1'b0;
    if (w_ld_done) begin
      load_done_stall = 1'b1;
      regD_out        = r_erd[r_head];
      load_data       = w_mem_rd;
    end else if (send_pulse) begin
      if (w_block) begin
        passive_stall = 1'b1;
      end else if (w_hit) begin
        hit_ack = 1'b1;
        if (lw) begin
          regD_out  = regD_in;
          load_data = r_data[w_hway][w_set];
        end
      end else if (lw) begin
        miss_send = 1'b1;
      end else begin
        hit_ack = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '{default: '0};
      r_dirty <= '{default: '0};
      r_pend  <= '{default: '0};
      r_mru   <= '0;
      r_occ   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_lat   <= '0;
    end else begin
      if (w_done) begin
        r_occ[r_head] <= 1'b0;
        r_head        <= f_inc(r_head);
        r_lat         <= '0;
        if (r_eload[r_head]) begin
          r_valid[r_eway[r_head]][w_hset] <= 1'b1;
          r_dirty[r_eway[r_head]][w_hset] <= 1'b0;
          r_pend[r_eway[r_head]][w_hset]  <= 1'b0;
        end
      end else if (r_count != '0) begin
        r_lat <= r_lat + c_LW'(1);
      end
      if (w_acc) begin
        if (w_hit) begin
          r_mru[w_set] <= w_hway;
          if (!lw) r_dirty[w_hway][w_set] <= 1'b1;
        end else begin
          r_mru[w_set]            <= w_vway;
          r_valid[w_vway][w_set]  <= !lw;
          r_dirty[w_vway][w_set]  <= !lw;
          r_pend[w_vway][w_set]   <= lw;
        end
      end
      if (w_enq_ld) r_occ[r_tail]    <= 1'b1;
      if (w_enq_ev) r_occ[w_ev_slot] <= 1'b1;
      r_tail  <= (w_enq_ld && w_enq_ev) ? w_tail2 :
                 (w_enq_ld || w_enq_ev) ? w_tail1 : r_tail;
      r_count <= r_count + c_CW'(w_enq_ld) + c_CW'(w_enq_ev) - c_CW'(w_done);
    end
  end

  // Payload arrays carry no reset; their validity is tracked by the bits above
  always_ff @(posedge clk) begin
    if (w_ld_done) begin
      r_tag[r_eway[r_head]][w_hset]  <= r_eaddr[r_head][29:6];
      r_data[r_eway[r_head]][w_hset] <= w_mem_rd;
    end
    if (w_acc && !lw) begin
      if (w_hit) begin
        r_data[w_hway][w_set] <= store_data;
      end else begin
        r_tag[w_vway][w_set]  <= w_tag;
        r_data[w_vway][w_set] <= store_data;
      end
    end
    if (w_enq_ld) begin
      r_eload[r_tail] <= 1'b1;
      r_eaddr[r_tail] <= addr_in[31:2];
      r_erd[r_tail]   <= regD_in;
      r_eway[r_tail]  <= w_vway;
    end
    if (w_enq_ev) begin
      r_eload[w_ev_slot] <= 1'b0;
      r_eaddr[w_ev_slot] <= {r_tag[w_vway][w_set], w_set};
      r_edata[w_ev_slot] <= r_data[w_vway][w_set];
    end
  end

  always_ff @(posedge clk) begin
    if (w_done && !r_eload[r_head])
      r_mem[r_eaddr[r_head][c_MW-1:0]] <= r_edata[r_head];
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_nb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_nb
// Brief    : Directed self-checking bench for dcache_nb; completions are
//            matched against a queue of expected {regD, data} pairs.
// Revision : 1.0
// ============================================================================
module tb_dcache_nb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        send_pulse = 1'b0;
  logic        lw = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  regD_in = '0;
  logic        hit_ack, miss_send, load_done_stall, passive_stall;
  logic [4:0]  regD_out;
  logic [31:0] load_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int          checks = 0;
  int          errors = 0;
  logic        stalled, hit, miss, any_stall;
  logic [4:0]  o_rd;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  dcache_nb dut (
    .clk             (clk),
    .rst             (rst),
    .send_pulse      (send_pulse),
    .lw              (lw),
    .addr_in         (addr_in),
    .store_data      (store_data),
    .regD_in         (regD_in),
    .hit_ack         (hit_ack),
    .miss_send       (miss_send),
    .regD_out        (regD_out),
    .load_data       (load_data),
    .load_done_stall (load_done_stall),
    .passive_stall   (passive_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && load_done_stall) begin
      chk("done_expected", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("done_regD", {27'b0, regD_out}, {27'b0, mon_e.rd});
        chk("done_data", load_data, mon_e.data);
        chk("done_no_ack", {30'b0, hit_ack, miss_send}, 32'd0);
      end
    end
  end

  // Store data always equals the address, so every cached word equals its address.
  task automatic req(input logic ld, input logic [31:0] a, input logic [4:0] rd);
    bit acc = 1'b0;
    send_pulse = 1'b1; lw = ld; addr_in = a; store_data = a; regD_in = rd;
    stalled = 1'b0; hit = 1'b0; miss = 1'b0; o_rd = '0; o_data = '0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (passive_stall) stalled = 1'b1;
      if (hit_ack || miss_send) begin
        acc = 1'b1; hit = hit_ack; miss = miss_send; o_rd = regD_out; o_data = load_data;
      end
    end
    chk("accept_in_time", {31'b0, acc}, 32'd1);
    @(posedge clk); #1;
    send_pulse = 1'b0;
  endtask

  task automatic hit_req(input string tag, input logic ld, input logic [31:0] a, input logic [4:0] rd);
    req(ld, a, rd);
    chk({tag, "_hit"}, {31'b0, hit}, 32'd1);
    chk({tag, "_miss"}, {31'b0, miss}, 32'd0);
    if (ld) begin
      chk({tag, "_data"}, o_data, a);
      chk({tag, "_rd"}, {27'b0, o_rd}, {27'b0, rd});
    end
  endtask

  task automatic miss_req(input string tag, input logic [31:0] a, input logic [4:0] rd, input logic [31:0] d);
    req(1'b1, a, rd);
    chk({tag, "_miss"}, {31'b0, miss}, 32'd1);
    chk({tag, "_hit"}, {31'b0, hit}, 32'd0);
    if (miss) q.push_back('{rd: rd, data: d});
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
    chk("drain_completions", 32'(q.size()), 32'd0);
    repeat (24) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hit_ack"}, {31'b0, hit_ack}, 32'd0);
    chk({tag, "_miss_send"}, {31'b0, miss_send}, 32'd0);
    chk({tag, "_done"}, {31'b0, load_done_stall}, 32'd0);
    chk({tag, "_pstall"}, {31'b0, passive_stall}, 32'd0);
    chk({tag, "_regD"}, {27'b0, regD_out}, 32'd0);
    chk({tag, "_data"}, load_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill sets 0..7: tag 1 into way 0, tag 0 into way 1, all dirty
    for (int i = 0; i < 8; i++) hit_req("st1xx", 1'b0, 32'h100 + 32'(4 * i), 5'd0);
    for (int i = 0; i < 8; i++) hit_req("st0xx", 1'b0, 32'(4 * i), 5'd0);

    // Each store evicts a dirty 0x10x line; the MSHR fills and stalls
    any_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit_req("st2xx", 1'b0, 32'h200 + 32'(4 * i), 5'd0);
      any_stall |= stalled;
      hit_req("ld2xx", 1'b1, 32'h200 + 32'(4 * i), 5'(i));
    end
    chk("st2xx_stall_seen", {31'b0, any_stall}, 32'd1);

    // Load miss reads back the word written by the earlier evict
    miss_req("ld100", 32'h100, 5'd12, 32'h100);
    drain();
    hit_req("ld100_fill", 1'b1, 32'h100, 5'd13);

    // Fill the MSHR with four evicts; a fifth evicting store stalls
    any_stall = 1'b0;
    for (int i = 1; i < 5; i++) begin
      hit_req("st3xx", 1'b0, 32'h300 + 32'(4 * i), 5'd0);
      any_stall |= stalled;
    end
    chk("st3xx_no_stall", {31'b0, any_stall}, 32'd0);
    hit_req("st314", 1'b0, 32'h314, 5'd0);
    chk("st314_stall", {31'b0, stalled}, 32'd1);
    hit_req("st024", 1'b0, 32'h24, 5'd0);
    chk("st024_no_stall", {31'b0, stalled}, 32'd0);
    hit_req("ld024", 1'b1, 32'h24, 5'd3);
    drain();

    // Push 0x100 out of set 0, then re-request it behind its own miss
    hit_req("st000", 1'b0, 32'h000, 5'd0);
    hit_req("st400", 1'b0, 32'h400, 5'd0);
    drain();
    miss_req("ld22", 32'h100, 5'd22, 32'h100);
    hit_req("st104", 1'b0, 32'h104, 5'd23);
    hit_req("ld24", 1'b1, 32'h100, 5'd24);
    chk("ld24_stall", {31'b0, stalled}, 32'd1);
    chk("ld24_after_done", 32'(q.size()), 32'd0);

    // Store to an address whose evict is still queued
    hit_req("st204", 1'b0, 32'h204, 5'd0);
    chk("st204_stall", {31'b0, stalled}, 32'd1);
    miss_req("ld304", 32'h304, 5'd5, 32'h304);
    drain();
    hit_req("ld204", 1'b1, 32'h204, 5'd6);
    hit_req("ld304h", 1'b1, 32'h304, 5'd7);

    // Reset with a load miss outstanding: no completion may follow
    miss_req("ld500", 32'h500, 5'd9, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk_idle("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    miss_req("ld500b", 32'h500, 5'd9, 32'h0);
    miss_req("ld100r", 32'h100, 5'd10, 32'h100);
    drain();
    hit_req("ld100h", 1'b1, 32'h100, 5'd11);

    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
